// File: rtl/cla_multiword_sequencer.sv
// Wide add/subtract built by stepping one 16-bit hierarchical CLA across
// WORDS slices, least-significant slice first, with a registered inter-slice carry.

module CLA_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out,
  output logic        BP,
  output logic        BG
);
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  // First level: 4-bit lookahead groups, each fed by a group carry from level two
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      logic [3:0] pn;
      logic [3:0] gn;
      assign pn = p[4*gi +: 4];
      assign gn = g[4*gi +: 4];

      assign gp[gi] = &pn;
      assign gg[gi] = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1]) |
                      (pn[3] & pn[2] & pn[1] & gn[0]);

      assign c[4*gi]     = gc[gi];
      assign c[4*gi + 1] = gn[0] | (pn[0] & gc[gi]);
      assign c[4*gi + 2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & gc[gi]);
      assign c[4*gi + 3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0]) |
                           (pn[2] & pn[1] & pn[0] & gc[gi]);
    end
  endgenerate

  assign gc[0] = c_in;
  assign gc[1] = gg[0] | (gp[0] & c_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
                 (gp[2] & gp[1] & gp[0] & c_in);

  assign BP = &gp;
  assign BG = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
              (gp[3] & gp[2] & gp[1] & gg[0]);
  assign gc[4] = BG | (BP & c_in);

  assign s     = p ^ c;
  assign c_out = gc[4];
endmodule

module cla_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                c_out,
  output logic                overflow
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [IW-1:0] idx_reg;
  logic          carry_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          c_out_reg;
  logic          ovf_reg;

  logic [15:0]   cla_a;
  logic [15:0]   cla_b;
  logic [15:0]   cla_s;
  logic          cla_c;
  logic          top_slice;

  assign top_slice = (idx_reg == IW'(WORDS - 1));

  // Slice select; idx never exceeds WORDS-1 so the default is never used in RUN
  always_comb begin
    cla_a = '0;
    cla_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_reg == IW'(i)) begin
        cla_a = a_reg[16*i +: 16];
        cla_b = b_reg[16*i +: 16];
      end
    end
  end

  CLA_16_bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .c_in (carry_reg),
    .s    (cla_s),
    .c_out(cla_c),
    .BP   (),
    .BG   ()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (top_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial slice carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub;
            idx_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_reg == IW'(i)) begin
              sum_reg[16*i +: 16] <= cla_s;
            end
          end
          carry_reg <= cla_c;
          if (top_slice) begin
            c_out_reg <= cla_c;
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (cla_s[15] != a_reg[W-1]);
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign c_out    = c_out_reg;
  assign overflow = ovf_reg;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed bench for cla_multiword_sequencer (WORDS=4): arithmetic reference
// model compared every cycle, plus hand-computed literal results.

module tb_cla_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  cla_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_sub  (op_sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .c_out   (c_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: exact W+1 bit unsigned sum and W+2 bit signed result
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rs);
    logic [W:0]   full;
    logic [W+1:0] ex;
    full = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + {{W{1'b0}}, rs};
    if (rs) ex = {{2{ra[W-1]}}, ra} - {{2{rb[W-1]}}, rb};
    else    ex = {{2{ra[W-1]}}, ra} + {{2{rb[W-1]}}, rb};
    return {(ex[W] != ex[W-1]), full};
  endfunction

  function automatic logic [W-1:0] low_mask(input int k);
    logic [W:0] one;
    one = {{W{1'b0}}, 1'b1};
    return W'((one << (16 * k)) - 1'b1);
  endfunction

  // Model: m_left counts cycles until back in IDLE (WORDS run + 1 done)
  int           m_left = 0;
  int           m_k = 0;
  logic [W-1:0] res_sum = '0;
  logic         res_c = 1'b0;
  logic         res_ov = 1'b0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_c = 1'b0;
  logic         exp_ov = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= 0;
      m_k     <= 0;
      exp_sum <= '0;
      exp_c   <= 1'b0;
      exp_ov  <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        logic [W+1:0] r;
        r = ref_result(a, b, op_sub);
        res_sum <= r[W-1:0];
        res_c   <= r[W];
        res_ov  <= r[W+1];
        m_left  <= WORDS + 1;
        m_k     <= 0;
        exp_sum <= '0;
      end
    end else if (m_left > 1) begin
      exp_sum <= res_sum & low_mask(m_k + 1);
      if (m_k + 1 == WORDS) begin
        exp_c  <= res_c;
        exp_ov <= res_ov;
      end
      m_k    <= m_k + 1;
      m_left <= m_left - 1;
    end else begin
      m_left <= 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_left > 0));
    chk("done", W'(done), W'(m_left == 1));
    chk("sum", sum, exp_sum);
    chk("c_out", W'(c_out), W'(exp_c));
    chk("overflow", W'(overflow), W'(exp_ov));
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input logic eo);
    int lat;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_v; op_sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_sub = ~ts;
    lat = 0;
    seen = 0;
    repeat (20) begin
      if (!seen) begin
        lat++;
        if (done) seen = 1;
        else @(negedge clk);
      end
    end
    chk({nm, "_done_seen"}, W'(seen), W'(1));
    chk({nm, "_latency"}, W'(lat), W'(WORDS + 1));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_c_out"}, W'(c_out), W'(ec));
    chk({nm, "_overflow"}, W'(overflow), W'(eo));
    $display("op %s a=%h b=%h sub=%0d -> sum=%h c=%0d ovf=%0d lat=%0d",
             nm, ta, tb_v, ts, sum, c_out, overflow, lat);
  endtask

  initial begin
    int dcount;
    bit first_seen;

    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_sum", sum, W'(0));
    rst = 1'b0;

    run_op("ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
           64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // start held high with operands changing every cycle: two ops, first uses first operands
    @(negedge clk);
    a = 64'h1111_2222_3333_4444; b = 64'h0101_0101_0101_0101; op_sub = 1'b0; start = 1'b1;
    dcount = 0;
    first_seen = 0;
    for (int i = 1; i <= 2 * (WORDS + 2); i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (!first_seen) begin
          first_seen = 1;
          chk("hold_first_sum", sum, 64'h1212_2323_3434_4545);
          chk("hold_first_lat", W'(i), W'(WORDS + 1));
        end
      end
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_sub = 1'($urandom);
    end
    start = 1'b0;
    chk("hold_done_count", W'(dcount), W'(2));
    $display("op hold_start done_pulses=%0d", dcount);
    repeat (2) @(negedge clk);

    // reset two cycles into RUN
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_sum", sum, W'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("rst_no_done", W'(dcount), W'(0));
    $display("op reset_mid_run busy=%0d sum=%h late_done=%0d", busy, sum, dcount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla_multiword_sequencer.md
Name: cla_multiword_sequencer

Overview:
- Multi-cycle controller that performs wide add/subtract by sequencing one instantiated CLA_16_bit across 16-bit slices, LSB slice first.
- Latches operands on a start handshake and feeds one slice per cycle.
- Ripples the inter-slice carry through a register and reports sum, carry-out and signed overflow with a done pulse.
- Sits between the ALU control path and the 16-bit hierarchical CLA datapath, so that a single adder instance serves 32/48/64-bit operations.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  W  result, registered.
- c_out  output  1  carry out of the top slice (for subtract, 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, immediate): state=IDLE; slice index=0; carry reg=0; operand regs=0; sum=0; c_out=0; overflow=0; busy=0; done=0. Asserting rst mid-operation aborts the operation, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a into A_r; latch b, or ~b when op_sub=1, into B_r; latch op_sub; carry reg <= op_sub; idx <= 0; sum <= 0; -> RUN.
  - start=0: stay in IDLE; sum, c_out and overflow hold their last values.
- RUN:
  - CLA inputs: a=A_r[16*idx+:16], b=B_r[16*idx+:16], c_in=carry reg.
  - Each edge: sum[16*idx+:16] <= CLA s; carry reg <= CLA c_out; idx <= idx+1.
  - Top slice (idx = WORDS-1): also c_out <= CLA c_out; overflow <= (A_r[W-1]==B_r[W-1]) && (CLA s[15] != A_r[W-1]); -> DONE.
  - RUN lasts exactly WORDS cycles.
- DONE: done=1 for exactly one cycle; -> IDLE.
- Latency: start accepted at edge N -> done high during the cycle after edge N+WORDS. There is no back-to-back start; a start during DONE is ignored, and the next start is accepted in IDLE one cycle later.
- start while busy is ignored: operands are not re-sampled and the state is unaffected.
- a, b and op_sub may change freely after acceptance; only the latched copies are used.
- idx counter width is clog2(WORDS), minimum 1 bit. Idx wraps to 0 on entering IDLE. There is no out-of-range slice access.
- The BP/BG outputs of CLA_16_bit are left unconnected.
- sum, c_out and overflow are stable from done until the next accepted start. On acceptance, sum clears to 0.
- WORDS=1: RUN lasts 1 cycle. The result must equal a single CLA_16_bit evaluation.

Test Plan:
- Reset mid-run (WORDS=4): start add, assert rst after 2 RUN cycles. Required: busy=0, sum=0 and done=0 immediately; no done pulse afterwards.
- Carry ripple across slices: a=0x0000_0000_0000_FFFF, b=0x1, op_sub=0. Required: sum=0x0000_0000_0001_0000, c_out=0, overflow=0, done exactly 5 cycles after the start edge.
- Full-width carry out and wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, add. Required: sum=0, c_out=1, overflow=0.
- Signed overflow on add and subtract:
  - Add: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1. Required: sum=0x8000_0000_0000_0000, overflow=1, c_out=0.
  - Subtract: a=0x8000_0000_0000_0000, b=0x1. Required: sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1, c_out=1.
- Borrow: op_sub=1, a=0x5, b=0x7. Required: sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0.
- Handshake robustness: hold start=1 continuously and change a/b during RUN. Required:
  - only the first operands are used;
  - done pulses once;
  - the next operation is accepted only in IDLE;
  - busy never drops during RUN.
